// File: rtl/char_overlay_if.sv
// Host-write and font-ROM bus of the character overlay.
// master: host/ROM side (drives writes, clear, fontData; sees busy, fontAddress).
// slave : overlay side (owns busy and fontAddress).
interface char_overlay_if;
  logic        wrEnable;
  logic [9:0]  wrAddress;
  logic [10:0] wrData;
  logic        clearRequest;
  logic        busy;
  logic [11:0] fontAddress;
  logic [7:0]  fontData;

  modport master (
    output wrEnable, wrAddress, wrData, clearRequest, fontData,
    input  busy, fontAddress
  );

  modport slave (
    input  wrEnable, wrAddress, wrData, clearRequest, fontData,
    output busy, fontAddress
  );
endinterface

// File: rtl/char_overlay.sv
// Character-cell text overlay: 40x18 host-written cell buffer, glyph fetch from
// an external font ROM, 16x16-pixel cells serialised to 1-bit-per-colour RGB.
// Latency: RGB registered on the pixelEnable edge of its pixel; fetch is 3 clks.
// Backpressure: none; host writes are dropped while busy (buffer clear running).
// Ports: clk/nReset; video timing strobes pixelEnable, lineStart, fieldStart,
// activeVideo; host write + font ROM bus on the slave modport; redOut/greenOut/blueOut.
module char_overlay #(
  parameter int COLUMNS = 40,
  parameter int ROWS    = 18,
  parameter int H_START = 40,
  parameter int V_START = 16
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               pixelEnable,
  input  logic               lineStart,
  input  logic               fieldStart,
  input  logic               activeVideo,
  char_overlay_if.slave      bus,
  output logic               redOut,
  output logic               greenOut,
  output logic               blueOut
);

  localparam int DEPTH = COLUMNS * ROWS;
  localparam int H_END = H_START + 16 * COLUMNS;
  localparam int V_END = V_START + 16 * ROWS;

  // ---------------------------------------------------------------- clear FSM
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t     state, state_nxt;
  logic [9:0] clr_addr, clr_addr_nxt;
  logic       clearing;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      S_IDLE: begin
        if (bus.clearRequest) begin
          state_nxt    = S_CLEAR;
          clr_addr_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (clr_addr == 10'(DEPTH - 1)) begin
          state_nxt    = S_IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + 10'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign clearing = (state == S_CLEAR);
  assign bus.busy = clearing;

  // ----------------------------------------------------------- character RAM
  // Single write port shared by the clear sweep and the host; the clear wins.
  logic [10:0] ram [DEPTH];
  logic        ram_we;
  logic [9:0]  ram_wa;
  logic [10:0] ram_wd;

  always_comb begin
    ram_we = 1'b0;
    ram_wa = bus.wrAddress;
    ram_wd = bus.wrData;
    if (clearing) begin
      ram_we = 1'b1;
      ram_wa = clr_addr;
      ram_wd = '0;
    end else if (bus.wrEnable && (bus.wrAddress < 10'(DEPTH))) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  // ---------------------------------------------------------------- counters
  logic [9:0] h_pixel;
  logic [8:0] v_line;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      h_pixel <= '0;
      v_line  <= '0;
    end else begin
      if (lineStart)                       h_pixel <= '0;
      else if (pixelEnable && activeVideo) h_pixel <= h_pixel + 10'd1;
      // fieldStart has priority so a coincident lineStart still yields line 0
      if (fieldStart)     v_line <= '0;
      else if (lineStart) v_line <= v_line + 9'd1;
    end
  end

  // ------------------------------------------------------------- text window
  logic [9:0] hx;
  logic [8:0] vy;
  logic       h_in, v_in;
  logic [5:0] cur_col;
  logic       cell_start;

  assign hx      = h_pixel - 10'(H_START);
  assign vy      = v_line - 9'(V_START);
  assign h_in    = (h_pixel >= 10'(H_START)) && (h_pixel < 10'(H_END));
  assign v_in    = (v_line >= 9'(V_START)) && (v_line < 9'(V_END));
  assign cur_col = hx[9:4];
  // First pixel of a cell: hand the prefetched glyph over and fetch the next one
  assign cell_start = pixelEnable && activeVideo && h_in && (hx[3:0] == 4'd0);

  // ---------------------------------------------------------- fetch pipeline
  logic        req_vld;
  logic [5:0]  req_col;
  logic [15:0] rd_idx;
  logic        rd_ok;
  logic        s1_vld, s2_vld;
  logic [10:0] s1_dat;
  logic [2:0]  s2_colour;
  logic [11:0] font_addr_q;
  logic [7:0]  pre_glyph, act_glyph;
  logic [2:0]  pre_colour, act_colour;

  assign rd_idx = 16'(vy[8:4]) * 16'(COLUMNS) + 16'(req_col);
  // Rows outside the window index past the buffer; treat those as empty cells
  assign rd_ok  = !clearing && (rd_idx < 16'(DEPTH));
  assign bus.fontAddress = font_addr_q;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      req_vld     <= 1'b0;
      req_col     <= '0;
      s1_vld      <= 1'b0;
      s1_dat      <= '0;
      s2_vld      <= 1'b0;
      s2_colour   <= '0;
      font_addr_q <= '0;
      pre_glyph   <= '0;
      pre_colour  <= '0;
      act_glyph   <= '0;
      act_colour  <= '0;
    end else begin
      req_vld <= 1'b0;
      if (lineStart) begin
        req_vld <= 1'b1;
        req_col <= '0;
      end else if (cell_start && (cur_col < 6'(COLUMNS - 1))) begin
        req_vld <= 1'b1;
        req_col <= cur_col + 6'd1;
      end

      s1_vld <= req_vld;
      if (req_vld) s1_dat <= rd_ok ? ram[rd_idx[9:0]] : '0;

      s2_vld <= s1_vld;
      if (s1_vld) begin
        font_addr_q <= {s1_dat[7:0], vy[3:0]};
        s2_colour   <= s1_dat[10:8];
      end

      if (s2_vld) begin
        pre_glyph  <= bus.fontData;
        pre_colour <= s2_colour;
      end

      if (cell_start) begin
        act_glyph  <= pre_glyph;
        act_colour <= pre_colour;
      end
    end
  end

  // ------------------------------------------------------------------ output
  // On a cell's first pixel the active buffer is only being loaded, so the
  // pixel is taken straight from the prefetch buffer.
  logic [7:0] sel_glyph;
  logic [2:0] sel_colour;
  logic       pix_on;

  assign sel_glyph  = cell_start ? pre_glyph  : act_glyph;
  assign sel_colour = cell_start ? pre_colour : act_colour;
  assign pix_on     = h_in && v_in && sel_glyph[3'd7 - hx[3:1]];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      redOut   <= 1'b0;
      greenOut <= 1'b0;
      blueOut  <= 1'b0;
    end else if (pixelEnable) begin
      {redOut, greenOut, blueOut} <= pix_on ? sel_colour : 3'b000;
    end
  end

endmodule

// File: tb/tb_char_overlay.sv
module tb_char_overlay;
  logic clk;
  logic nReset;
  logic pixelEnable, lineStart, fieldStart, activeVideo;
  logic redOut, greenOut, blueOut;
  logic [2:0] rgb;

  int checks = 0;
  int errors = 0;
  int cur_line;
  int nz;
  int hold_bad;
  int n;
  logic [2:0] px [0:719];

  char_overlay_if bus();

  char_overlay dut (
    .clk        (clk),
    .nReset     (nReset),
    .pixelEnable(pixelEnable),
    .lineStart  (lineStart),
    .fieldStart (fieldStart),
    .activeVideo(activeVideo),
    .bus        (bus),
    .redOut     (redOut),
    .greenOut   (greenOut),
    .blueOut    (blueOut)
  );

  assign rgb = {redOut, greenOut, blueOut};

  // Combinational font ROM: data settles within the clk after fontAddress moves.
  function automatic logic [7:0] font_rom(input logic [11:0] a);
    case (a[11:4])
      8'h41:   font_rom = (a[3:0] == 4'd0) ? 8'h80 : 8'h00;
      8'h42:   font_rom = 8'h0F;
      8'h43:   font_rom = 8'hF0;
      8'hFF:   font_rom = 8'hFF;
      default: font_rom = 8'hAA;
    endcase
  endfunction

  assign bus.fontData = font_rom(bus.fontAddress);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [9:0] a, input logic [10:0] d);
    bus.wrEnable  = 1'b1;
    bus.wrAddress = a;
    bus.wrData    = d;
    @(negedge clk);
    bus.wrEnable  = 1'b0;
  endtask

  task automatic new_field();
    fieldStart = 1'b1;
    lineStart  = 1'b1;
    @(negedge clk);
    fieldStart = 1'b0;
    lineStart  = 1'b0;
    cur_line   = 0;
  endtask

  task automatic goto_line(input int target);
    while (cur_line < target) begin
      lineStart = 1'b1;
      @(negedge clk);
      lineStart = 1'b0;
      cur_line++;
      repeat (2) @(negedge clk);
    end
  endtask

  // Drive cnt pixels (pixelEnable every other clk), record RGB per pixel,
  // optionally issue one host write in the idle clk after pixel wr_at.
  task automatic draw_pixels(input int cnt, input int wr_at,
                             input logic [9:0] wa, input logic [10:0] wd);
    nz = 0;
    hold_bad = 0;
    for (int i = 0; i < 720; i++) px[i] = 3'b000;
    repeat (10) @(negedge clk);
    for (int i = 0; i < cnt; i++) begin
      pixelEnable = 1'b1;
      activeVideo = 1'b1;
      @(negedge clk);
      px[i] = rgb;
      pixelEnable = 1'b0;
      if (i == wr_at) begin
        bus.wrEnable  = 1'b1;
        bus.wrAddress = wa;
        bus.wrData    = wd;
      end
      @(negedge clk);
      bus.wrEnable = 1'b0;
      if (rgb !== px[i]) hold_bad++;
      if (px[i] !== 3'b000) nz++;
    end
    activeVideo = 1'b0;
  endtask

  // Count clks with busy high; optionally poke clearRequest / a write mid-clear.
  task automatic measure_busy(input int req_at, input int wr_at, output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 2000) begin
      if (cnt == req_at) bus.clearRequest = 1'b1;
      if (cnt == wr_at) begin
        bus.wrEnable  = 1'b1;
        bus.wrAddress = 10'd0;
        bus.wrData    = {3'b111, 8'hFF};
      end
      @(negedge clk);
      cnt++;
      bus.clearRequest = 1'b0;
      bus.wrEnable     = 1'b0;
    end
  endtask

  initial begin
    nReset = 1'b0;
    pixelEnable = 1'b0;
    lineStart = 1'b0;
    fieldStart = 1'b0;
    activeVideo = 1'b0;
    bus.wrEnable = 1'b0;
    bus.wrAddress = '0;
    bus.wrData = '0;
    bus.clearRequest = 1'b0;
    cur_line = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rgb", rgb, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_fontaddr", bus.fontAddress, 0);

    // Release: clear lasts 720 clks even with clearRequest and a write mid-clear
    nReset = 1'b1;
    measure_busy(300, 500, n);
    check("rst_busy_len", n, 720);

    // Field after reset is blank (the mid-clear write to cell 0 must not show)
    new_field();
    goto_line(16);
    draw_pixels(690, -1, 10'd0, 11'd0);
    check("blank_l16", nz, 0);
    goto_line(303);
    draw_pixels(690, -1, 10'd0, 11'd0);
    check("blank_l303", nz, 0);

    // First and last cells; out-of-range address is dropped
    host_write(10'd0,   {3'b100, 8'h41});
    host_write(10'd719, {3'b011, 8'hFF});
    host_write(10'd720, {3'b111, 8'hFF});
    host_write(10'd1023, {3'b111, 8'hFF});
    new_field();
    goto_line(16);
    draw_pixels(690, -1, 10'd0, 11'd0);
    check("l16_px39", px[39], 0);
    check("l16_px40", px[40], 4);
    check("l16_px41", px[41], 4);
    check("l16_px42", px[42], 0);
    check("l16_count", nz, 2);
    check("l16_hold", hold_bad, 0);
    for (int l = 300; l <= 303; l++) begin
      goto_line(l);
      draw_pixels(690, -1, 10'd0, 11'd0);
      check($sformatf("l%0d_px663", l), px[663], 0);
      check($sformatf("l%0d_px664", l), px[664], 3);
      check($sformatf("l%0d_px679", l), px[679], 3);
      check($sformatf("l%0d_px680", l), px[680], 0);
      check($sformatf("l%0d_count", l), nz, 16);
    end
    goto_line(304);
    draw_pixels(690, -1, 10'd0, 11'd0);
    check("l304_count", nz, 0);

    // Rewrite a cell while it is on screen: old glyph this line, new next line
    host_write(10'd45, {3'b010, 8'h43});
    new_field();
    goto_line(32);
    draw_pixels(690, 125, 10'd45, {3'b001, 8'h42});
    check("l32_px120", px[120], 2);
    check("l32_px127", px[127], 2);
    check("l32_px128", px[128], 0);
    check("l32_count", nz, 8);
    goto_line(33);
    draw_pixels(690, -1, 10'd0, 11'd0);
    check("l33_px120", px[120], 0);
    check("l33_px128", px[128], 1);
    check("l33_px135", px[135], 1);
    check("l33_count", nz, 8);

    // Fill everything white, then clear
    for (int a = 0; a < 720; a++) host_write(10'(a), {3'b111, 8'hFF});
    new_field();
    goto_line(16);
    draw_pixels(690, -1, 10'd0, 11'd0);
    check("fill_px40", px[40], 7);
    check("fill_px679", px[679], 7);
    check("fill_count", nz, 640);
    check("clr_busy_before", bus.busy, 0);
    bus.clearRequest = 1'b1;
    @(negedge clk);
    bus.clearRequest = 1'b0;
    check("clr_busy_rise", bus.busy, 1);
    measure_busy(-1, -1, n);
    check("clr_busy_len", n, 720);
    new_field();
    goto_line(16);
    draw_pixels(690, -1, 10'd0, 11'd0);
    check("clr_l16", nz, 0);
    goto_line(200);
    draw_pixels(690, -1, 10'd0, 11'd0);
    check("clr_l200", nz, 0);
    goto_line(303);
    draw_pixels(690, -1, 10'd0, 11'd0);
    check("clr_l303", nz, 0);

    // Reset in the middle of a lit cell
    host_write(10'd0, {3'b110, 8'hFF});
    new_field();
    goto_line(16);
    draw_pixels(46, -1, 10'd0, 11'd0);
    check("mid_px40", px[40], 6);
    check("mid_rgb_before", rgb, 6);
    nReset = 1'b0;
    #1;
    check("mid_rgb_async", rgb, 0);
    check("mid_busy", bus.busy, 1);
    @(negedge clk);
    nReset = 1'b1;
    draw_pixels(60, -1, 10'd0, 11'd0);
    check("mid_after_count", nz, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
